// File: rtl/microsequencer.sv
// Microsequencer: uinstr = fixed fetch words at steps 0/1, else the ROM word at {opcode, tstate}, combinational; tstate advances each edge (RT returns it to 0).
// Define MICROSEQUENCER_SINGLESTEP_EN to advance only on step_req, with uinstr gated to 0x0000 while stalled and a step_ack pulse after each step.
module microsequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  opcode,
    input  logic [15:0] ucode_data,
    output logic [10:0] ucode_addr,
    output logic [15:0] uinstr,
    output logic [2:0]  tstate,
    output logic        fetch,
    input  logic        step_req,
    output logic        step_ack
);

    localparam logic [15:0] FETCH0_WORD = 16'h0040;
    localparam logic [15:0] FETCH1_WORD = 16'h3480;

`ifdef MICROSEQUENCER_SINGLESTEP_EN
    localparam bit SINGLESTEP = 1'b1;
`else
    localparam bit SINGLESTEP = 1'b0;
`endif

    logic [2:0]  tstate_q, tstate_d;
    logic        step_ack_q, step_ack_d;
    logic        advance;
    logic        stalled;
    logic        is_rt;
    logic [15:0] uinstr_raw;

    always_comb begin
        case (tstate_q)
            3'd0:    uinstr_raw = FETCH0_WORD;
            3'd1:    uinstr_raw = FETCH1_WORD;
            default: uinstr_raw = ucode_data;
        endcase
    end

    always_comb begin
        advance = 1'b1;
        stalled = 1'b0;
        if (SINGLESTEP) begin
            advance = step_req;
            // Reset keeps the fetch word visible even while stalled.
            stalled = !step_req && !reset;
        end
    end

    always_comb begin
        uinstr = stalled ? 16'h0000 : uinstr_raw;
        // Bit 11 only means RT for non-ALU words; with bit 15 set it is ALU NY.
        is_rt = !uinstr[15] && uinstr[11];

        tstate_d = tstate_q;
        if (advance) begin
            tstate_d = is_rt ? 3'd0 : tstate_q + 3'd1;
        end
        step_ack_d = SINGLESTEP && advance;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tstate_q   <= 3'd0;
            step_ack_q <= 1'b0;
        end else begin
            tstate_q   <= tstate_d;
            step_ack_q <= step_ack_d;
        end
    end

    assign tstate     = tstate_q;
    assign fetch      = (tstate_q == 3'd0);
    assign ucode_addr = {opcode, tstate_q};
    assign step_ack   = step_ack_q;

endmodule

// File: tb/tb_microsequencer.sv
// Bench for microsequencer: directed scenarios plus a randomized run against a step-level model.
module tb_microsequencer;

`ifdef MICROSEQUENCER_SINGLESTEP_EN
    localparam bit SS = 1'b1;
`else
    localparam bit SS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  opcode;
    logic [15:0] ucode_data;
    logic [10:0] ucode_addr;
    logic [15:0] uinstr;
    logic [2:0]  tstate;
    logic        fetch;
    logic        step_req;
    logic        step_ack;

    logic [15:0] rom [0:2047];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign ucode_data = rom[ucode_addr];

    microsequencer dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .ucode_data (ucode_data),
        .ucode_addr (ucode_addr),
        .uinstr     (uinstr),
        .tstate     (tstate),
        .fetch      (fetch),
        .step_req   (step_req),
        .step_ack   (step_ack)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rom_fill(input logic [15:0] v);
        for (int i = 0; i < 2048; i++) rom[i] = v;
    endtask

    // Pulse reset away from the clock edge; leaves the DUT at tstate 0.
    task automatic pulse_reset;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        step_req = 1'b1;
        opcode   = 8'h12;
        rom_fill(16'h0000);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (tstate !== 3'd5) begin
            failures++;
            $display("FAIL reset_pre_step5 tstate=%0d expected=5", tstate);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (tstate !== 3'd0) begin
            failures++;
            $display("FAIL reset_tstate got=%0d expected=0", tstate);
        end
        checks++;
        if (uinstr !== 16'h0040) begin
            failures++;
            $display("FAIL reset_uinstr got=%h expected=0040", uinstr);
        end
        checks++;
        if (ucode_addr !== 11'h090) begin
            failures++;
            $display("FAIL reset_addr got=%h expected=090", ucode_addr);
        end
        checks++;
        if (fetch !== 1'b1 || step_ack !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags fetch=%b step_ack=%b expected 1/0", fetch, step_ack);
        end
    endtask

    task automatic test_fetch;
        logic [7:0] op1, op2;
        op1 = 8'($urandom_range(0, 255));
        op2 = op1 ^ 8'h5A;
        rom[{op1, 3'd0}] = 16'hFFFF;
        rom[{op1, 3'd1}] = 16'h0800;
        rom[{op1, 3'd2}] = 16'h0800;
        rom[{op2, 3'd2}] = 16'h1234;
        opcode = op1;
        tick();                         // reset still held from test_reset
        reset = 1'b0;
        #1;
        checks++;
        if (tstate !== 3'd0 || uinstr !== 16'h0040) begin
            failures++;
            $display("FAIL fetch_step0 tstate=%0d uinstr=%h expected 0/0040", tstate, uinstr);
        end
        tick();
        checks++;
        if (tstate !== 3'd1 || uinstr !== 16'h3480) begin
            failures++;
            $display("FAIL fetch_step1 tstate=%0d uinstr=%h expected 1/3480", tstate, uinstr);
        end
        tick();
        opcode = op2;                   // IR loaded at the step-1 edge
        #1;
        checks++;
        if (ucode_addr !== {op2, 3'd2}) begin
            failures++;
            $display("FAIL fetch_addr2 got=%h expected=%h", ucode_addr, {op2, 3'd2});
        end
        checks++;
        if (uinstr !== 16'h1234) begin
            failures++;
            $display("FAIL fetch_uinstr2 got=%h expected=1234", uinstr);
        end
    endtask

    task automatic test_rt;
        opcode = 8'hA7;
        rom[{8'hA7, 3'd2}] = 16'h0000;
        rom[{8'hA7, 3'd3}] = 16'h0800;
        tick();
        pulse_reset();
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (tstate !== 3'd3 || uinstr !== 16'h0800) begin
            failures++;
            $display("FAIL rt_step3 tstate=%0d uinstr=%h expected 3/0800", tstate, uinstr);
        end
        tick();
        checks++;
        if (tstate !== 3'd0 || fetch !== 1'b1) begin
            failures++;
            $display("FAIL rt_return tstate=%0d fetch=%b expected 0/1", tstate, fetch);
        end
    endtask

    task automatic test_eo_alias;
        opcode = 8'h3C;
        rom[{8'h3C, 3'd2}] = 16'h8800;
        tick();
        pulse_reset();
        tick();
        tick();
        checks++;
        if (uinstr !== 16'h8800) begin
            failures++;
            $display("FAIL eo_uinstr got=%h expected=8800", uinstr);
        end
        tick();
        checks++;
        if (tstate !== 3'd3) begin
            failures++;
            $display("FAIL eo_alias tstate=%0d expected=3", tstate);
        end
    endtask

    task automatic test_wrap;
        rom_fill(16'h0000);
        opcode = 8'h55;
        tick();
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (tstate !== 3'(i % 8)) begin
                failures++;
                $display("FAIL wrap_seq idx=%0d tstate=%0d expected=%0d", i, tstate, i % 8);
            end
            tick();
        end
    endtask

`ifdef MICROSEQUENCER_SINGLESTEP_EN
    task automatic test_singlestep;
        rom_fill(16'h0000);
        opcode = 8'h21;
        rom[{8'h21, 3'd2}] = 16'h0123;
        step_req = 1'b1;
        tick();
        pulse_reset();
        tick();
        tick();
        step_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (uinstr !== 16'h0000 || tstate !== 3'd2) begin
                failures++;
                $display("FAIL ss_stall cyc=%0d uinstr=%h tstate=%0d expected 0000/2", i, uinstr, tstate);
            end
            tick();
            checks++;
            if (step_ack !== 1'b0) begin
                failures++;
                $display("FAIL ss_stall_ack cyc=%0d step_ack=%b expected=0", i, step_ack);
            end
        end
        step_req = 1'b1;
        #1;
        checks++;
        if (uinstr !== 16'h0123) begin
            failures++;
            $display("FAIL ss_pulse_uinstr got=%h expected=0123", uinstr);
        end
        tick();
        step_req = 1'b0;
        #1;
        checks++;
        if (tstate !== 3'd3 || step_ack !== 1'b1) begin
            failures++;
            $display("FAIL ss_step tstate=%0d step_ack=%b expected 3/1", tstate, step_ack);
        end
        tick();
        checks++;
        if (tstate !== 3'd3 || step_ack !== 1'b0) begin
            failures++;
            $display("FAIL ss_ack_once tstate=%0d step_ack=%b expected 3/0", tstate, step_ack);
        end
    endtask
`else
    task automatic test_step_ignored;
        rom_fill(16'h0000);
        opcode = 8'h44;
        tick();
        pulse_reset();
        for (int i = 0; i < 6; i++) begin
            step_req = i[0];
            tick();
            checks++;
            if (tstate !== 3'(i + 1) || step_ack !== 1'b0) begin
                failures++;
                $display("FAIL step_ignored i=%0d tstate=%0d step_ack=%b expected %0d/0", i, tstate, step_ack, i + 1);
            end
        end
    endtask
`endif

    // Step-level reference model: current step number, pending acknowledge.
    task automatic test_random;
        int          t;
        bit          ack_exp;
        bit          adv;
        logic [15:0] u_exp;
        for (int i = 0; i < 2048; i++) rom[i] = 16'($urandom);
        step_req = 1'b1;
        tick();
        pulse_reset();
        t = 0;
        ack_exp = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            opcode   = 8'($urandom_range(0, 255));
            step_req = SS ? ($urandom_range(0, 3) != 0) : $urandom_range(0, 1) == 1;
            #1;
            if (SS && !step_req) u_exp = 16'h0000;
            else if (t == 0)     u_exp = 16'h0040;
            else if (t == 1)     u_exp = 16'h3480;
            else                 u_exp = rom[opcode * 8 + t];
            checks++;
            if (tstate !== 3'(t) || fetch !== (t == 0)) begin
                failures++;
                $display("FAIL rand_state cyc=%0d tstate=%0d fetch=%b expected %0d", cyc, tstate, fetch, t);
            end
            checks++;
            if (ucode_addr !== 11'(opcode * 8 + t)) begin
                failures++;
                $display("FAIL rand_addr cyc=%0d got=%h expected=%h", cyc, ucode_addr, opcode * 8 + t);
            end
            checks++;
            if (uinstr !== u_exp) begin
                failures++;
                $display("FAIL rand_uinstr cyc=%0d got=%h expected=%h", cyc, uinstr, u_exp);
            end
            checks++;
            if (step_ack !== ack_exp) begin
                failures++;
                $display("FAIL rand_ack cyc=%0d got=%b expected=%b", cyc, step_ack, ack_exp);
            end
            adv = SS ? step_req : 1'b1;
            ack_exp = SS && adv;
            if (adv) t = (u_exp[15] == 1'b0 && u_exp[11] == 1'b1) ? 0 : (t + 1) % 8;
            tick();
            if ($urandom_range(0, 39) == 0) begin
                pulse_reset();
                t = 0;
                ack_exp = 1'b0;
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        step_req = 1'b0;
        opcode   = 8'h00;
        rom_fill(16'h0000);
        test_reset();
        test_fetch();
        test_rt();
        test_eo_alias();
        test_wrap();
`ifdef MICROSEQUENCER_SINGLESTEP_EN
        test_singlestep();
`else
        test_step_ignored();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
